// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch stage: issues word fetches under a credit limit and buffers
// in-order responses in a small FIFO. Redirects flush the FIFO and drop in-flight data.
module if_prefetch_stage #(
    parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    input  logic        id_ready_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [OUT_W-1:0] discard_q, discard_d;

    logic [31:0] pc_mem    [FIFO_DEPTH];
    logic [31:0] instr_mem [FIFO_DEPTH];

    logic gnt_fire;
    logic push;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits count both buffered and in-flight words, so every kept response has a slot.
    assign instr_req_o = !rst_i && !branch_taken_i
                         && (out_q < OUT_W'(MAX_OUTSTANDING))
                         && ((32'(count_q) + 32'(out_q)) < 32'(FIFO_DEPTH));
    assign instr_addr_o = fetch_pc_q;

    assign if_valid_o = (count_q != '0);
    assign if_pc_o    = pc_mem[rd_ptr_q];
    assign if_instr_o = instr_mem[rd_ptr_q];

    always_comb begin
        gnt_fire   = instr_req_o && instr_gnt_i;
        push       = instr_rvalid_i && (discard_q == '0) && !branch_taken_i;
        pop        = if_valid_o && id_ready_i && !branch_taken_i;

        fetch_pc_d = gnt_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
        resp_pc_d  = push ? resp_pc_q + 32'd4 : resp_pc_q;
        out_d      = out_q + OUT_W'(gnt_fire) - OUT_W'(instr_rvalid_i);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        discard_d  = discard_q;
        if (instr_rvalid_i && (discard_q != '0)) begin
            discard_d = discard_q - OUT_W'(1);
        end

        // Everything still in flight after this cycle belongs to the old stream.
        if (branch_taken_i) begin
            fetch_pc_d = branch_target_i & WORD_MASK;
            resp_pc_d  = branch_target_i & WORD_MASK;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            discard_d  = out_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_ADDR & WORD_MASK;
            resp_pc_q  <= RESET_ADDR & WORD_MASK;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            out_q      <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            out_q      <= out_d;
            discard_q  <= discard_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            pc_mem[wr_ptr_q]    <= resp_pc_q;
            instr_mem[wr_ptr_q] <= instr_rdata_i;
        end
    end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: in-order memory responder with optional hold,
// expected-PC queue checked on every consumed instruction, plus per-scenario spot checks.
module tb_if_prefetch_stage;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

    logic        clk_i;
    logic        rst_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        id_ready_i;

    logic        rsp_hold;
    int          grant_cnt;
    int          errors;
    int          checks;
    logic [31:0] rsp_q[$];
    logic [31:0] exp_q[$];

    if_prefetch_stage #(
        .RESET_ADDR(RESET_ADDR),
        .FIFO_DEPTH(4),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .branch_taken_i (branch_taken_i),
        .branch_target_i(branch_target_i),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .if_valid_o     (if_valid_o),
        .if_pc_o        (if_pc_o),
        .if_instr_o     (if_instr_o),
        .id_ready_i     (id_ready_i)
    );

    // Clock and time bound
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0F69;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory: a grant sampled at edge N returns data sampled at edge N+1 unless held.
    initial begin
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = 32'h0;
    end

    always @(posedge clk_i) begin
        if (rst_i) begin
            rsp_q.delete();
            instr_rvalid_i <= 1'b0;
            grant_cnt      <= 0;
        end else begin
            if (instr_req_o && instr_gnt_i) begin
                rsp_q.push_back(instr_addr_o);
                grant_cnt <= grant_cnt + 1;
            end
            instr_rvalid_i <= 1'b0;
            if (!rsp_hold && rsp_q.size() > 0) begin
                instr_rvalid_i <= 1'b1;
                instr_rdata_i  <= mem_word(rsp_q.pop_front());
            end
        end
    end

    // Scoreboard: every instruction decode consumes must be the next expected PC.
    always @(negedge clk_i) begin
        if (!rst_i && !branch_taken_i && if_valid_o && id_ready_i) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", {31'b0, if_valid_o}, 32'h0);
            end else begin
                automatic logic [31:0] e = exp_q.pop_front();
                check("pop_pc", if_pc_o, e);
                check("pop_instr", if_instr_o, mem_word(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i           = 1'b1;
        branch_taken_i  = 1'b0;
        branch_target_i = 32'h0;
        instr_gnt_i     = 1'b0;
        id_ready_i      = 1'b0;
        rsp_hold        = 1'b0;
        tick();
        tick();
        @(negedge clk_i);
        check("rst_req", {31'b0, instr_req_o}, 32'h0);
        check("rst_valid", {31'b0, if_valid_o}, 32'h0);
        check("pops_missing", exp_q.size(), 32'h0);
        exp_q.delete();
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rel_valid", {31'b0, if_valid_o}, 32'h0);
        check("rel_addr", instr_addr_o, RESET_ADDR);
        check("rel_req", {31'b0, instr_req_o}, 32'h1);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        do_reset();

        // Streaming: one PC per cycle from 0x0
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        instr_gnt_i = 1'b1;
        id_ready_i  = 1'b1;
        repeat (10) tick();
        do_reset();

        // Back-pressure: four grants fill the FIFO, then drain and resume at 0x10
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        instr_gnt_i = 1'b1;
        repeat (8) tick();
        id_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_req_full", {31'b0, instr_req_o}, 32'h0);
        check("bp_grants", grant_cnt, 32'd4);
        check("bp_valid", {31'b0, if_valid_o}, 32'h1);
        check("bp_head_pc", if_pc_o, 32'h0);
        tick();
        @(negedge clk_i);
        check("bp_resume_req", {31'b0, instr_req_o}, 32'h1);
        check("bp_resume_addr", instr_addr_o, 32'h10);
        repeat (5) tick();
        do_reset();

        // Grant stall: request and address held, nothing pushed
        id_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk_i);
            check("stall_req", {31'b0, instr_req_o}, 32'h1);
            check("stall_addr", instr_addr_o, 32'h0);
        end
        check("stall_valid", {31'b0, if_valid_o}, 32'h0);
        check("stall_grants", grant_cnt, 32'd0);
        do_reset();

        // Redirect with two outstanding: both responses dropped, stream restarts at 0x100
        exp_q = '{32'h100, 32'h104};
        instr_gnt_i = 1'b1;
        id_ready_i  = 1'b1;
        rsp_hold    = 1'b1;
        tick();
        tick();
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h0000_0103;
        @(negedge clk_i);
        check("br_req", {31'b0, instr_req_o}, 32'h0);
        tick();
        branch_taken_i = 1'b0;
        rsp_hold       = 1'b0;
        @(negedge clk_i);
        check("br_addr", instr_addr_o, 32'h100);
        check("br_req_credit", {31'b0, instr_req_o}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk_i);
            check("br_drop_valid", {31'b0, if_valid_o}, 32'h0);
        end
        tick();
        @(negedge clk_i);
        check("br_first_valid", {31'b0, if_valid_o}, 32'h1);
        check("br_first_pc", if_pc_o, 32'h100);
        tick();
        tick();
        do_reset();

        // Back-to-back redirects: only the 0x300 stream may ever appear
        exp_q = '{32'h300, 32'h304};
        instr_gnt_i = 1'b1;
        id_ready_i  = 1'b1;
        rsp_hold    = 1'b1;
        tick();
        tick();
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h200;
        tick();
        branch_target_i = 32'h300;
        rsp_hold        = 1'b0;
        tick();
        branch_taken_i = 1'b0;
        @(negedge clk_i);
        check("b2b_addr", instr_addr_o, 32'h300);
        check("b2b_valid", {31'b0, if_valid_o}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge clk_i);
            check("b2b_drop_valid", {31'b0, if_valid_o}, 32'h0);
        end
        tick();
        @(negedge clk_i);
        check("b2b_first_valid", {31'b0, if_valid_o}, 32'h1);
        check("b2b_first_pc", if_pc_o, 32'h300);
        tick();
        tick();
        do_reset();

        // Redirect in the same cycle as a response: that response is not counted twice
        exp_q = '{32'h40};
        instr_gnt_i = 1'b1;
        id_ready_i  = 1'b1;
        tick();
        tick();
        branch_taken_i  = 1'b1;
        branch_target_i = 32'h0000_0042;
        tick();
        branch_taken_i = 1'b0;
        @(negedge clk_i);
        check("brrv_addr", instr_addr_o, 32'h40);
        check("brrv_req", {31'b0, instr_req_o}, 32'h1);
        tick();
        @(negedge clk_i);
        check("brrv_valid_early", {31'b0, if_valid_o}, 32'h0);
        tick();
        @(negedge clk_i);
        check("brrv_valid", {31'b0, if_valid_o}, 32'h1);
        check("brrv_pc", if_pc_o, 32'h40);
        tick();
        do_reset();

        // Reset mid-stream with a non-empty FIFO
        instr_gnt_i = 1'b1;
        repeat (4) tick();
        @(negedge clk_i);
        check("mid_valid", {31'b0, if_valid_o}, 32'h1);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
